// File: rtl/imem_if.sv
// Fetch/load bus between the fetch stage (master) and the instruction memory responder (slave).
interface imem_if #(
    parameter int AW = 10
);
    logic          req;
    logic [31:0]   addr;
    logic          flush;
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_data;
    logic [31:0]   rdata;
    logic          ready;
    logic          err;
    logic          stall;

    modport master (
        output req, addr, flush, ld_en, ld_addr, ld_data,
        input  rdata, ready, err, stall
    );

    modport slave (
        input  req, addr, flush, ld_en, ld_addr, ld_data,
        output rdata, ready, err, stall
    );
endinterface

// File: rtl/imem_responder.sv
// Fixed-latency instruction memory: accepts one fetch at a time, answers LATENCY cycles later,
// supports flush abort and a program-load write port active in every state.
module imem_responder #(
    parameter int LATENCY = 2,
    parameter int AW      = 10
) (
    input logic   clk,
    input logic   rst,
    imem_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] areg_q, areg_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;

    logic [31:0] mem [1 << AW];

    logic [31:0] fetch_addr;
    logic        enter_resp;
    logic        out_of_range;

    // With LATENCY=1 the RESP-entry edge is the accepting edge, so the live addr must be used.
    always_comb begin
        fetch_addr   = (state_q == IDLE) ? bus.addr : areg_q;
        out_of_range = (fetch_addr >> (AW + 2)) != '0;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        areg_d     = areg_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        ready_d    = 1'b0;
        enter_resp = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req && !bus.flush) begin
                    areg_d = bus.addr;
                    if (LATENCY == 1) begin
                        state_d    = RESP;
                        cnt_d      = '0;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (bus.flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (enter_resp) begin
            ready_d = 1'b1;
            if (out_of_range) begin
                rdata_d = '0;
                err_d   = 1'b1;
            end else begin
                rdata_d = mem[fetch_addr[AW+1:2]];
                err_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            areg_q  <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            areg_q  <= areg_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    // Memory sits outside the reset branch: loads work during reset and contents survive it.
    always_ff @(posedge clk) begin
        if (bus.ld_en) begin
            mem[bus.ld_addr] <= bus.ld_data;
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.ready = ready_q;
    assign bus.err   = err_q;
    assign bus.stall = bus.req & ~ready_q;
endmodule

// File: tb/tb_imem_responder.sv
// Randomized scoreboard bench for imem_responder against a word-array reference model.
module tb_imem_responder;
    localparam int LAT = 2;
    localparam int AW  = 10;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imem_if #(.AW(AW)) bus ();

    imem_responder #(.LATENCY(LAT), .AW(AW)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [DEPTH];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          rst_seen = 1'b0;
    logic [31:0] last_rdata = '0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rst_seen <= !rst_n;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Reference: the memory is a plain word array; anything beyond its byte span is an error.
    function automatic void model_resp(input logic [31:0] a, output logic [31:0] d, output logic e);
        e = longint'(a) >= (longint'(1) << (AW + 2));
        d = e ? 32'h0 : model[int'(a / 4)];
    endfunction

    // Monitor: pops the scoreboard on every ready pulse, otherwise checks rdata holds.
    always @(negedge clk) begin
        if (rst_seen) begin
            check("rst_ready", {31'b0, bus.ready}, 32'd0);
            check("rst_err", {31'b0, bus.err}, 32'd0);
            check("rst_rdata", bus.rdata, 32'd0);
            last_rdata = '0;
        end else if (bus.ready) begin
            if (sb.size() == 0) begin
                check("unexpected_ready", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rdata", bus.rdata, e.data);
                check("err", {31'b0, bus.err}, {31'b0, e.err});
                check("ready_cycle", 32'(cyc), 32'(e.cyc));
            end
            last_rdata = bus.rdata;
        end else begin
            check("rdata_hold", bus.rdata, last_rdata);
        end
    end

    task automatic step();
        @(posedge clk);
        if (bus.ld_en) model[int'(bus.ld_addr)] = bus.ld_data;
        #1;
        bus.ld_en = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] a, input bit same_load, input bit noise);
        logic [31:0] d;
        logic        e;
        int          n;
        bus.req   = 1'b1;
        bus.addr  = a;
        bus.flush = 1'b0;
        n = cyc;
        #1 check("stall_accept", {31'b0, bus.stall}, 32'd1);
        for (int k = 0; k < LAT; k++) begin
            if (k > 0) begin
                if (noise) begin
                    bus.req  = 1'($urandom);
                    bus.addr = $urandom;
                end
                #1 check("stall_wait", {31'b0, bus.stall}, {31'b0, bus.req});
            end
            if (k == LAT - 1) begin
                model_resp(a, d, e);
                sb.push_back('{data: d, err: e, cyc: n + LAT});
            end
            if (same_load && k == LAT - 1) begin
                bus.ld_en   = 1'b1;
                bus.ld_addr = a[AW+1:2];
                bus.ld_data = 32'hDEADBEEF;
            end else if (noise && $urandom_range(3) == 0) begin
                bus.ld_en   = 1'b1;
                bus.ld_addr = AW'($urandom);
                bus.ld_data = $urandom;
            end
            step();
        end
        bus.req   = noise ? 1'($urandom) : 1'b1;
        bus.addr  = $urandom;
        bus.flush = noise ? ($urandom_range(3) == 0) : 1'b0;
        #1 check("stall_resp", {31'b0, bus.stall}, 32'd0);
        step();
        bus.req   = 1'b0;
        bus.flush = 1'b0;
    endtask

    task automatic do_flush(input logic [31:0] a, input int k);
        bus.req  = 1'b1;
        bus.addr = a;
        for (int j = 0; j <= k; j++) begin
            bus.flush = (j == k);
            step();
        end
        bus.req   = 1'b0;
        bus.flush = 1'b0;
    endtask

    task automatic do_reset_mid(input logic [31:0] a, input logic [AW-1:0] la, input logic [31:0] ld);
        bus.req  = 1'b1;
        bus.addr = a;
        step();
        rst_n       = 1'b0;
        bus.req     = 1'b0;
        bus.ld_en   = 1'b1;
        bus.ld_addr = la;
        bus.ld_data = ld;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        bus.req = 1'b0; bus.addr = '0; bus.flush = 1'b0;
        bus.ld_en = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;

        // Whole program image is loaded while reset is held.
        for (int i = 0; i < DEPTH; i++) begin
            bus.ld_en   = 1'b1;
            bus.ld_addr = AW'(i);
            bus.ld_data = (i == 0) ? 32'h80010C0A : (i == 1) ? 32'h04011000 : $urandom;
            step();
        end
        rst_n = 1'b1;
        step();

        do_fetch(32'h0, 1'b0, 1'b0);
        do_fetch(32'h4, 1'b0, 1'b0);
        step();
        do_flush(32'h8, 1);
        do_fetch(32'h30, 1'b0, 1'b0);
        do_fetch(32'h00001000, 1'b0, 1'b0);
        do_fetch(32'h40, 1'b1, 1'b0);
        do_fetch(32'h40, 1'b0, 1'b0);
        do_fetch(32'h43, 1'b0, 1'b0);
        do_reset_mid(32'h44, AW'(5), 32'hA5A5_0F0F);
        do_fetch(32'h44, 1'b0, 1'b0);
        do_fetch(32'h14, 1'b0, 1'b0);
        do_flush(32'h50, 0);
        do_fetch(32'h50, 1'b0, 1'b0);

        for (int r = 0; r < 300; r++) begin
            int sel;
            sel = $urandom_range(9);
            a = ($urandom_range(0, DEPTH - 1) << 2) | ($urandom & 32'd3);
            if (sel == 0) a = $urandom;
            if (sel == 1) do_flush(a, $urandom_range(0, LAT - 1));
            else do_fetch(a, 1'b0, 1'b1);
            if (sel == 2) step();
        end

        repeat (4) step();
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter LATENCY, default 2, sets cycles from request acceptance to response; legal range 1..15.
REQ-002 Parameter AW, default 10, sets log2 of word depth; the memory holds 2^AW 32-bit words.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous and active-low.
REQ-005 req  input  1  fetch request from the fetch stage; held high until ready.
REQ-006 addr  input  32  byte address of the fetch; word index is addr[AW+1:2].
REQ-007 flush  input  1  branch-taken abort of any outstanding fetch.
REQ-008 ld_en  input  1  program-load write strobe.
REQ-009 ld_addr  input  AW  word index for the program-load write.
REQ-010 ld_data  input  32  program-load write data.
REQ-011 rdata  output  32  fetched instruction word; valid only while ready=1.
REQ-012 ready  output  1  one-cycle pulse marking a valid response.
REQ-013 err  output  1  qualifies ready; set when the fetch address is out of range.
REQ-014 stall  output  1  freeze to the fetch stage, combinational: req & ~ready.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT and RESP, plus a 4-bit down-counter cnt.
REQ-016 IDLE with req=1 and flush=0 SHALL latch addr into areg, set cnt=LATENCY-1, and go to WAIT; when LATENCY=1 it goes directly to RESP.
REQ-017 WAIT SHALL decrement cnt each cycle; at cnt==1 the next state is RESP.
REQ-018 On entry to RESP, rdata SHALL load mem[areg[AW+1:2]] and ready=1 for exactly that one cycle, then the FSM returns to IDLE.
REQ-019 Latency: with req first high in cycle n while IDLE, ready SHALL be high in cycle n+LATENCY.
REQ-020 Changes of addr or req after acceptance SHALL be ignored; only flush aborts.
REQ-021 flush=1 in IDLE or WAIT SHALL return the FSM to IDLE with no ready pulse; a new req is accepted no earlier than the following cycle.
REQ-022 flush=1 in the RESP cycle SHALL NOT suppress that cycle's ready; the consumer discards the response.
REQ-023 If areg[31:AW+2] is nonzero, the response SHALL be rdata=0 and err=1, with the same timing; otherwise err=0.
REQ-024 addr[1:0] SHALL be ignored (word-aligned access).
REQ-025 Back-to-back: a request is accepted in the IDLE cycle following RESP, so issue rate is one fetch per LATENCY+1 cycles.
REQ-026 ld_en=1 SHALL write ld_data to mem[ld_addr] on the clock edge in any state, including during reset.
REQ-027 A load and a RESP-entry read of the same word on the same edge SHALL return the old data (read-before-write).
REQ-028 While ready=0, rdata SHALL hold its last value.

Reset
REQ-029 rst=0 sampled at a clock edge SHALL force state=IDLE, cnt=0, areg=0, rdata=0, ready=0 and err=0.
REQ-030 Reset SHALL NOT clear memory contents.
REQ-031 Reset asserted mid-fetch SHALL abandon the fetch with no ready pulse.

Verification
REQ-032 Load mem[0]=0x80010C0A and mem[1]=0x04011000; req=1, addr=0x0 with LATENCY=2 -> stall=1 in cycles n and n+1, ready=1 with rdata=0x80010C0A in cycle n+2, stall=0 in n+2.
REQ-033 Hold req high with addr stepping 0x0, 0x4 after each ready -> ready pulses spaced 3 cycles apart, rdata returns mem[0] then mem[1].
REQ-034 Accept req at addr 0x8, then flush=1 in the first WAIT cycle -> no ready pulse; a new req at addr 0x30 in the next cycle -> ready with mem[12] two cycles later.
REQ-035 req with addr=0x00001000 (AW=10) -> ready=1, err=1, rdata=0 at the normal latency.
REQ-036 On the RESP-entry edge, ld_en writes 0xDEADBEEF to the same word -> rdata returns the old word; a refetch returns 0xDEADBEEF.
REQ-037 rst=0 during WAIT -> ready, err and rdata are 0 next cycle, state is IDLE, and memory contents are retained on refetch.
